// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of one operation at a time from two
// requesters onto a shared combinational ALU, with a programmable settle
// latency and a tagged valid/ready response channel.
module alu_issue_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_instr,
    input  logic [31:0] req1_instr,
    input  logic [31:0] req0_a,
    input  logic [31:0] req1_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    output logic        busy
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [2:0]  rsp_flags_q, rsp_flags_d;
    logic        grant;

    // Round-robin pick: prio breaks ties, otherwise the lone requester wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = prio_q;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    // Next-state, datapath capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        instr_d      = instr_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    owner_d   = grant;
                    instr_d   = grant ? req1_instr : req0_instr;
                    a_d       = grant ? req1_a : req0_a;
                    b_d       = grant ? req1_b : req0_b;
                    cnt_d     = CNT_W'(ALU_LAT - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_id_d     = owner_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over any accept, capture or handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            instr_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            instr_q      <= instr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_instruction = instr_q;
    assign alu_regA        = a_q;
    assign alu_regB        = b_q;
    assign rsp_valid       = (state_q == RESP);
    assign rsp_id          = rsp_id_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_flags       = rsp_flags_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: one instance at ALU_LAT=1 driving a
// small MIPS ALU model, one at ALU_LAT=4 with a bench-driven ALU result.
module tb_alu_issue_arbiter;

    localparam logic [31:0] ADD = 32'h0001_1020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] r0_instr = '0, r1_instr = '0, r0_a = '0, r1_a = '0, r0_b = '0, r1_b = '0;

    logic [1:0]  rv1 = '0, rr1;
    logic        rsprdy1 = 1'b0;
    logic [31:0] ai1, aa1, ab1, ares1, res1;
    logic [2:0]  aflg1, flg1;
    logic        vld1, id1, busy1;

    logic [1:0]  rv4 = '0, rr4;
    logic        rsprdy4 = 1'b0;
    logic [31:0] ai4, aa4, ab4, res4;
    logic [31:0] ares4 = '0;
    logic [2:0]  aflg4 = '0, flg4;
    logic        vld4, id4, busy4;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
        .req0_instr(r0_instr), .req1_instr(r1_instr),
        .req0_a(r0_a), .req1_a(r1_a), .req0_b(r0_b), .req1_b(r1_b),
        .alu_instruction(ai1), .alu_regA(aa1), .alu_regB(ab1),
        .alu_result(ares1), .alu_flags(aflg1),
        .rsp_valid(vld1), .rsp_ready(rsprdy1), .rsp_id(id1),
        .rsp_result(res1), .rsp_flags(flg1), .busy(busy1)
    );

    alu_issue_arbiter #(.ALU_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rr4),
        .req0_instr(r0_instr), .req1_instr(r1_instr),
        .req0_a(r0_a), .req1_a(r1_a), .req0_b(r0_b), .req1_b(r1_b),
        .alu_instruction(ai4), .alu_regA(aa4), .alu_regB(ab4),
        .alu_result(ares4), .alu_flags(aflg4),
        .rsp_valid(vld4), .rsp_ready(rsprdy4), .rsp_id(id4),
        .rsp_result(res4), .rsp_flags(flg4), .busy(busy4)
    );

    // Combinational ALU model: R-type add/sub with signed overflow, slt, beq.
    always_comb begin
        ares1 = '0;
        aflg1 = '0;
        if (ai1[31:26] == 6'h00) begin
            case (ai1[5:0])
                6'h20: begin
                    ares1    = aa1 + ab1;
                    aflg1[2] = (aa1[31] == ab1[31]) && (ares1[31] != aa1[31]);
                end
                6'h22: begin
                    ares1    = aa1 - ab1;
                    aflg1[2] = (aa1[31] != ab1[31]) && (ares1[31] != aa1[31]);
                end
                6'h2A: begin
                    aflg1[1] = ($signed(aa1) < $signed(ab1));
                    ares1    = {31'b0, aflg1[1]};
                end
                default: ares1 = '0;
            endcase
        end else if (ai1[31:26] == 6'h04) begin
            aflg1[0] = (aa1 == ab1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // At most one requester may be offered ready in any cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rdy1_exclusive", {31'b0, rr1[0] & rr1[1]}, 32'd0);
            chk("rdy4_exclusive", {31'b0, rr4[0] & rr4[1]}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_rsp_valid", {31'b0, vld1}, 32'd0);
        chk("rst_req_ready", {30'b0, rr1}, 32'd0);
        chk("rst_alu_instr", ai1, 32'd0);
        chk("rst_rsp_result", res1, 32'd0);
        chk("rst_rsp_flags", {29'b0, flg1}, 32'd0);
        rst = 1'b0;
        tick();

        // Single add on requester 0, ALU_LAT=1
        r0_instr = ADD; r0_a = 32'd5; r0_b = 32'd7; rsprdy1 = 1'b1; rv1 = 2'b01;
        #1;
        chk("add_req_ready", {30'b0, rr1}, 32'd1);
        tick();
        rv1 = 2'b00;
        chk("add_alu_instr", ai1, ADD);
        chk("add_alu_a", aa1, 32'd5);
        chk("add_alu_b", ab1, 32'd7);
        chk("add_wait_valid", {31'b0, vld1}, 32'd0);
        chk("add_wait_ready", {30'b0, rr1}, 32'd0);
        tick();
        chk("add_rsp_valid", {31'b0, vld1}, 32'd1);
        chk("add_rsp_result", res1, 32'd12);
        chk("add_rsp_flags", {29'b0, flg1}, 32'd0);
        chk("add_rsp_id", {31'b0, id1}, 32'd0);
        tick();
        chk("add_idle_busy", {31'b0, busy1}, 32'd0);
        chk("add_idle_valid", {31'b0, vld1}, 32'd0);

        // Both valid from reset: alternation over 8 operations
        r0_instr = ADD; r0_a = 32'd1; r0_b = 32'd100;
        r1_instr = ADD; r1_a = 32'd2; r1_b = 32'd200;
        rv1 = 2'b11; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int op = 0; op < 8; op++) begin
            #1;
            chk("alt_req_ready", {30'b0, rr1}, (op % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
            chk("alt_rsp_valid", {31'b0, vld1}, 32'd1);
            chk("alt_rsp_id", {31'b0, id1}, (op % 2 == 0) ? 32'd0 : 32'd1);
            chk("alt_rsp_result", res1, (op % 2 == 0) ? 32'd101 : 32'd202);
            tick();
        end

        // Response back-pressure with req1 pending
        rv1 = 2'b01; rsprdy1 = 1'b0;
        #1;
        chk("bp_req_ready", {30'b0, rr1}, 32'd1);
        tick();
        rv1 = 2'b10;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", {31'b0, vld1}, 32'd1);
            chk("bp_hold_result", res1, 32'd101);
            chk("bp_hold_id", {31'b0, id1}, 32'd0);
            chk("bp_hold_ready", {30'b0, rr1}, 32'd0);
            tick();
        end
        rsprdy1 = 1'b1;
        #1;
        chk("bp_release_ready", {30'b0, rr1}, 32'd0);
        tick();
        chk("bp_after_hs_valid", {31'b0, vld1}, 32'd0);
        chk("bp_req1_ready", {30'b0, rr1}, 32'd2);
        tick();
        rv1 = 2'b00;
        chk("bp_req1_alu_a", aa1, 32'd2);
        chk("bp_req1_alu_b", ab1, 32'd200);
        tick();
        chk("bp_req1_id", {31'b0, id1}, 32'd1);
        chk("bp_req1_result", res1, 32'd202);
        tick();

        // Signed overflow add
        r0_instr = ADD; r0_a = 32'h7FFF_FFFF; r0_b = 32'd1; rv1 = 2'b01;
        tick();
        rv1 = 2'b00;
        tick();
        chk("ovf_result", res1, 32'h8000_0000);
        chk("ovf_flags", {29'b0, flg1}, 32'd4);
        tick();

        // ALU_LAT=4: inputs held, result sampled only at E0+4
        r0_instr = ADD; r0_a = 32'h11; r0_b = 32'h22; rv4 = 2'b01; rsprdy4 = 1'b1;
        #1;
        chk("lat4_req_ready", {30'b0, rr4}, 32'd1);
        tick();
        rv4 = 2'b00;
        r0_a = 32'h99;
        for (int k = 0; k < 4; k++) begin
            chk("lat4_alu_instr", ai4, ADD);
            chk("lat4_alu_a", aa4, 32'h11);
            chk("lat4_alu_b", ab4, 32'h22);
            chk("lat4_wait_valid", {31'b0, vld4}, 32'd0);
            ares4 = (k == 3) ? 32'h1234_5678 : 32'hDEAD_0000 + 32'(k);
            aflg4 = (k == 3) ? 3'b010 : 3'b101;
            tick();
        end
        ares4 = 32'hBAD0_BAD0; aflg4 = 3'b111;
        chk("lat4_rsp_valid", {31'b0, vld4}, 32'd1);
        chk("lat4_rsp_result", res4, 32'h1234_5678);
        chk("lat4_rsp_flags", {29'b0, flg4}, 32'd2);
        tick();
        chk("lat4_idle_busy", {31'b0, busy4}, 32'd0);

        // Reset during WAIT drops the operation and clears prio
        r1_instr = ADD; r1_a = 32'h33; r1_b = 32'h44; rv4 = 2'b10;
        #1;
        chk("rstw_req1_ready", {30'b0, rr4}, 32'd2);
        tick();
        tick();
        chk("rstw_busy_before", {31'b0, busy4}, 32'd1);
        rst = 1'b1; rv4 = 2'b00;
        tick();
        rst = 1'b0;
        chk("rstw_busy", {31'b0, busy4}, 32'd0);
        chk("rstw_req_ready", {30'b0, rr4}, 32'd0);
        chk("rstw_alu_instr", ai4, 32'd0);
        chk("rstw_alu_a", aa4, 32'd0);
        chk("rstw_alu_b", ab4, 32'd0);
        chk("rstw_rsp_result", res4, 32'd0);
        chk("rstw_rsp_flags", {29'b0, flg4}, 32'd0);
        chk("rstw_rsp_id", {31'b0, id4}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            chk("rstw_no_rsp", {31'b0, vld4}, 32'd0);
            tick();
        end
        rv4 = 2'b11;
        #1;
        chk("rstw_prio_req0", {30'b0, rr4}, 32'd1);
        tick();
        rv4 = 2'b00;
        tick();
        tick();
        tick();
        tick();
        chk("rstw_re_rsp_valid", {31'b0, vld4}, 32'd1);
        chk("rstw_re_rsp_id", {31'b0, id4}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
